button_input_bank: RTL
======================

BUTTON_INPUT_BANK -- requirements
Module: button_input_bank

Interface
REQ-001 Parameter NUM_CH, default 10, number of button channels (two players x 5 buttons).
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000, consecutive clock edges an input must hold a new value before it is accepted; legal range 1 or more.
REQ-003 Parameter INVERT_MASK[NUM_CH-1:0], default all 0; a set bit marks that channel's pin as active-low.
REQ-004 Parameter REPEAT_DELAY, default 25000000, cycles from a press to the first auto-repeat.
REQ-005 Parameter REPEAT_PERIOD, default 5000000, cycles between subsequent auto-repeats.
REQ-006 Clock and reset are fixed: one clock; reset is synchronous and active-low.
REQ-007 clk  input  1  system clock; every flop is rising-edge clk.
REQ-008 rst  input  1  synchronous, active-low reset.
REQ-009 btn_i  input  NUM_CH  raw asynchronous button pins.
REQ-010 ack_i  input  NUM_CH  per-channel clear of pend_o.
REQ-011 level_o  output  NUM_CH  debounced active-high button state.
REQ-012 press_o  output  NUM_CH  one-cycle pulse on an accepted press, or on an auto-repeat.
REQ-013 release_o  output  NUM_CH  one-cycle pulse on an accepted release.
REQ-014 pend_o  output  NUM_CH  sticky press-pending flag.

Function
REQ-015 Each channel SHALL XOR its pin with INVERT_MASK[i], then pass it through a 2-flop synchroniser; channels are fully independent.
REQ-016 Per-channel counter width SHALL be $clog2(DEBOUNCE_CYCLES)+1, with no wrap.
REQ-017 Each edge, if the synchronised input equals level_o[i], the counter SHALL clear to 0.
REQ-018 Each edge, if the synchronised input differs from level_o[i] and the counter equals DEBOUNCE_CYCLES-1, level_o[i] SHALL take the synchronised value and the counter SHALL clear; otherwise the counter SHALL increment.
REQ-019 Latency SHALL be exactly DEBOUNCE_CYCLES+1 edges, measured from the edge at which the first synchroniser flop captures the new value to the edge at which level_o changes.
REQ-020 Any bounce back to the old value before acceptance SHALL restart the count from 0 and SHALL produce no pulse.
REQ-021 press_o[i] (rise) or release_o[i] (fall) SHALL be registered high on the same edge that level_o[i] changes, for exactly one cycle.
REQ-022 pend_o[i] SHALL be set by any press_o[i] pulse and cleared by ack_i[i]=1.
REQ-023 When a set condition and ack_i[i] occur in the same cycle, pend_o[i] SHALL end that cycle at 1, so no press is lost.
REQ-024 ack_i[i] while pend_o[i]=0 SHALL have no effect.
REQ-025 Each channel SHALL be in exactly one of the states IDLE (level 0), CONFIRM_PRESS, HELD (level 1), CONFIRM_RELEASE.
REQ-026 Channel states SHALL transition per REQ-017/018: IDLE->CONFIRM_PRESS on mismatch, CONFIRM_PRESS->HELD on count done, CONFIRM_PRESS->IDLE on match; HELD and CONFIRM_RELEASE transition symmetrically.

Reset
REQ-027 While rst=0 at an edge, level_o, press_o, release_o, pend_o, the synchroniser flops (post-inversion value 0) and all counters SHALL be 0.
REQ-028 Reset asserted mid-count SHALL discard the count; after reset deasserts, a held button SHALL require the full REQ-019 latency before a press is accepted.

Configuration
REQ-029 Macro BUTTON_AUTOREPEAT_EN SHALL be the only compile-time option.
REQ-030 With BUTTON_AUTOREPEAT_EN defined, while level_o[i]=1 a repeat counter SHALL emit press_o[i] pulses (and set pend_o[i]) REPEAT_DELAY cycles after the accepted press, then every REPEAT_PERIOD cycles; release or reset SHALL stop and clear it.
REQ-031 With BUTTON_AUTOREPEAT_EN undefined, no repeat logic SHALL be generated, REPEAT_* SHALL be ignored, and press_o SHALL pulse once per accepted press.

Structure
REQ-032 Package button_input_pkg SHALL hold the default constants (NUM_CH, DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) and the 2-bit channel-state enum.
REQ-033 Sub-module button_channel (synchroniser, counter, state, pulses, pend, optional repeat) SHALL implement one channel and be instantiated NUM_CH times in a generate loop.

Verification (DEBOUNCE_CYCLES=4, NUM_CH=10 unless stated)
REQ-034 Clean press: ch0 pin 0->1, held 12 cycles -> level_o[0] rises 5 edges after the capture edge, one press_o[0] pulse, pend_o[0]=1, other channels unchanged.
REQ-035 Bounce: ch3 pin toggles every 2 cycles for 12 cycles, then holds 1 -> no pulse during bouncing, exactly one press_o[3] pulse 5 edges after the final capture.
REQ-036 Ack collision: ack_i[0]=1 in the same cycle as a press_o[0] pulse -> pend_o[0] stays 1; ack_i[0]=1 one cycle later -> pend_o[0]=0.
REQ-037 Polarity and simultaneity: INVERT_MASK[9]=1; ch9 pin 1->0 and ch0 pin 0->1 on the same cycle -> press_o[0] and press_o[9] pulse on the same edge; on release, release_o pulses for both.
REQ-038 Reset mid-count: rst=0 when ch2 counter=3 -> all outputs 0 next edge; after rst=1 with pin held 1 -> press accepted 5 edges after the first capture edge.
REQ-039 Auto-repeat (BUTTON_AUTOREPEAT_EN defined, REPEAT_DELAY=8, REPEAT_PERIOD=3): hold ch1 for 20 cycles after press at edge t -> press_o[1] pulses at t, t+8, t+11, t+14, t+17; with the macro undefined, only at t.

Source files
------------

// File: rtl/button_input_bank_pkg.sv
// Shared defaults and the per-channel debounce state encoding for the button input bank.
package button_input_pkg;

  localparam int NUM_CH_DEF          = 10;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int REPEAT_DELAY_DEF    = 25000000;
  localparam int REPEAT_PERIOD_DEF   = 5000000;

  // Bit 1 of the encoding is the debounced level, so it can be read straight from the state.
  typedef enum logic [1:0] {
    ST_IDLE            = 2'b00,
    ST_CONFIRM_PRESS   = 2'b01,
    ST_HELD            = 2'b10,
    ST_CONFIRM_RELEASE = 2'b11
  } ch_state_e;

endpackage

// File: rtl/button_input_bank_if.sv
// Pin, acknowledge and event bus of the button input bank.
interface button_input_bank_if
  import button_input_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF
);

  logic [NUM_CH-1:0] btn_i;
  logic [NUM_CH-1:0] ack_i;
  logic [NUM_CH-1:0] level_o;
  logic [NUM_CH-1:0] press_o;
  logic [NUM_CH-1:0] release_o;
  logic [NUM_CH-1:0] pend_o;

  modport master (
    output btn_i, ack_i,
    input  level_o, press_o, release_o, pend_o
  );

  modport slave (
    input  btn_i, ack_i,
    output level_o, press_o, release_o, pend_o
  );

endinterface

// File: rtl/button_input_bank_channel.sv
// One button channel: synchroniser, debounce FSM, event pulses, sticky pending flag.
// Auto-repeat is built only when BUTTON_AUTOREPEAT_EN is defined.
//
//   state              | meaning
//   ST_IDLE            | level 0, input agrees
//   ST_CONFIRM_PRESS   | level 0, input high, counting toward acceptance
//   ST_HELD            | level 1, input agrees
//   ST_CONFIRM_RELEASE | level 1, input low, counting toward acceptance
module button_channel
  import button_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit INVERT          = 1'b0,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  input  logic i_ack,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_pend
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  ch_state_e       r_state;
  ch_state_e       w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_level;
  logic            w_rise;
  logic            w_fall;
  logic            w_rpt_fire;
  logic            r_press;
  logic            r_release;
  logic            r_pend;

  assign w_level = (r_state == ST_HELD) || (r_state == ST_CONFIRM_RELEASE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    if (r_sync2 == w_level) begin
      w_cnt_nxt   = '0;
      w_state_nxt = w_level ? ST_HELD : ST_IDLE;
    end else if (r_cnt == CNT_LAST) begin
      w_cnt_nxt   = '0;
      w_state_nxt = w_level ? ST_IDLE : ST_HELD;
      w_rise      = ~w_level;
      w_fall      = w_level;
    end else begin
      w_cnt_nxt   = r_cnt + CW'(1);
      w_state_nxt = w_level ? ST_CONFIRM_RELEASE : ST_CONFIRM_PRESS;
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int            RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int            RW      = $clog2(RPT_MAX) + 1;

  logic [RW-1:0] r_rpt_cnt;

  // Down-counter armed on the accepted press; a terminal count while held fires and reloads.
  assign w_rpt_fire = w_level && !w_fall && (r_rpt_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rpt_cnt <= '0;
    end else if (w_rise) begin
      r_rpt_cnt <= RW'(REPEAT_DELAY - 1);
    end else if (!w_level || w_fall) begin
      r_rpt_cnt <= '0;
    end else if (r_rpt_cnt == '0) begin
      r_rpt_cnt <= RW'(REPEAT_PERIOD - 1);
    end else begin
      r_rpt_cnt <= r_rpt_cnt - RW'(1);
    end
  end
`else
  assign w_rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_pend    <= 1'b0;
    end else begin
      r_sync1   <= i_btn ^ INVERT;
      r_sync2   <= r_sync1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_rise | w_rpt_fire;
      r_release <= w_fall;
      // Set wins over ack, so a press arriving with an ack is never dropped.
      r_pend    <= r_press | (r_pend & ~i_ack);
    end
  end

  assign o_level   = w_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_pend    = r_pend;

endmodule

// File: rtl/button_input_bank.sv
// Bank of independent debounced button channels with press/release pulses and pending flags.
// Optional auto-repeat on held buttons is enabled by defining BUTTON_AUTOREPEAT_EN.
module button_input_bank
  import button_input_pkg::*;
#(
  parameter int                NUM_CH          = NUM_CH_DEF,
  parameter int                DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic [NUM_CH-1:0] INVERT_MASK     = '0,
  parameter int                REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int                REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic                clk,
  input  logic                rst,
  button_input_bank_if.slave  bus
);

  logic [NUM_CH-1:0] w_level;
  logic [NUM_CH-1:0] w_press;
  logic [NUM_CH-1:0] w_release;
  logic [NUM_CH-1:0] w_pend;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INVERT          (INVERT_MASK[g]),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_btn     (bus.btn_i[g]),
      .i_ack     (bus.ack_i[g]),
      .o_level   (w_level[g]),
      .o_press   (w_press[g]),
      .o_release (w_release[g]),
      .o_pend    (w_pend[g])
    );
  end

  assign bus.level_o   = w_level;
  assign bus.press_o   = w_press;
  assign bus.release_o = w_release;
  assign bus.pend_o    = w_pend;

endmodule
